// File: rtl/rename_table_multiway.sv
// N-way register rename unit: speculative + committed maps, free bitmaps, intra-group bypass.
// Optional RENAME_PARTIAL_ACCEPT_EN: accept the longest fitting prefix instead of all-or-nothing.
module rename_table_multiway #(
  parameter int WIDTH           = 3,
  parameter int COMMIT_WIDTH    = 3,
  parameter int ARCH_REGS       = 32,
  parameter int PHYS_REGS       = 64,
  parameter int ARCH_ADDR_WIDTH = $clog2(ARCH_REGS),
  parameter int PHYS_ADDR_WIDTH = $clog2(PHYS_REGS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [WIDTH-1:0]                        in_valid,
  input  logic [WIDTH-1:0]                        rd_we,
  input  logic [WIDTH*ARCH_ADDR_WIDTH-1:0]        rs1_arch,
  input  logic [WIDTH*ARCH_ADDR_WIDTH-1:0]        rs2_arch,
  input  logic [WIDTH*ARCH_ADDR_WIDTH-1:0]        rd_arch,
  output logic                                    in_ready,
  output logic [WIDTH-1:0]                        accepted,
  output logic [WIDTH*PHYS_ADDR_WIDTH-1:0]        rs1_phys,
  output logic [WIDTH*PHYS_ADDR_WIDTH-1:0]        rs2_phys,
  output logic [WIDTH*PHYS_ADDR_WIDTH-1:0]        rd_phys,
  output logic [WIDTH*PHYS_ADDR_WIDTH-1:0]        old_rd_phys,
  input  logic [COMMIT_WIDTH-1:0]                 commit_valid,
  input  logic [COMMIT_WIDTH*ARCH_ADDR_WIDTH-1:0] commit_rd_arch,
  input  logic [COMMIT_WIDTH*PHYS_ADDR_WIDTH-1:0] commit_new_phys,
  input  logic [COMMIT_WIDTH*PHYS_ADDR_WIDTH-1:0] commit_old_phys,
  input  logic                                    flush,
  output logic [PHYS_ADDR_WIDTH:0]                free_count
);

  localparam int AW = ARCH_ADDR_WIDTH;
  localparam int PW = PHYS_ADDR_WIDTH;
  localparam int CW = PHYS_ADDR_WIDTH + 1;

  logic [PW-1:0]        spec_rat_reg    [ARCH_REGS];
  logic [PW-1:0]        spec_rat_next   [ARCH_REGS];
  logic [PW-1:0]        commit_rat_reg  [ARCH_REGS];
  logic [PW-1:0]        commit_rat_next [ARCH_REGS];
  logic [PHYS_REGS-1:0] spec_free_reg, spec_free_next;
  logic [PHYS_REGS-1:0] commit_free_reg, commit_free_next;

  logic [AW-1:0] rs1_a [WIDTH];
  logic [AW-1:0] rs2_a [WIDTH];
  logic [AW-1:0] rd_a  [WIDTH];
  logic [AW-1:0] c_arch [COMMIT_WIDTH];
  logic [PW-1:0] c_new  [COMMIT_WIDTH];
  logic [PW-1:0] c_old  [COMMIT_WIDTH];

  logic [PW-1:0] cand     [WIDTH];
  logic [PW-1:0] raw_rd   [WIDTH];
  logic [PW-1:0] rs1_out  [WIDTH];
  logic [PW-1:0] rs2_out  [WIDTH];
  logic [PW-1:0] rd_out   [WIDTH];
  logic [PW-1:0] old_out  [WIDTH];
  logic [CW-1:0] need_before [WIDTH];
  logic [CW-1:0] need_upto   [WIDTH];
  logic [WIDTH-1:0] need;
  logic [WIDTH-1:0] fit_mask;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slot
      assign rs1_a[gi] = rs1_arch[gi*AW +: AW];
      assign rs2_a[gi] = rs2_arch[gi*AW +: AW];
      assign rd_a[gi]  = rd_arch[gi*AW +: AW];
      assign need[gi]  = in_valid[gi] & rd_we[gi] & (rd_a[gi] != '0);
      assign raw_rd[gi] = need[gi] ? cand[gi] : '0;
      assign rs1_phys[gi*PW +: PW]    = rs1_out[gi];
      assign rs2_phys[gi*PW +: PW]    = rs2_out[gi];
      assign rd_phys[gi*PW +: PW]     = rd_out[gi];
      assign old_rd_phys[gi*PW +: PW] = old_out[gi];
    end
    for (gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_commit
      assign c_arch[gi] = commit_rd_arch[gi*AW +: AW];
      assign c_new[gi]  = commit_new_phys[gi*PW +: PW];
      assign c_old[gi]  = commit_old_phys[gi*PW +: PW];
    end
  endgenerate

  // Running count of allocating slots; slot i takes the need_before[i]-th free register.
  always_comb begin : p_need_count
    logic [CW-1:0] run;
    run = '0;
    for (int i = 0; i < WIDTH; i++) begin
      need_before[i] = run;
      run = run + CW'(need[i]);
      need_upto[i] = run;
    end
  end

  always_comb begin : p_free_count
    free_count = '0;
    for (int p = 0; p < PHYS_REGS; p++)
      free_count = free_count + CW'(spec_free_reg[p]);
  end

  always_comb begin : p_alloc_scan
    logic [CW-1:0] seen;
    seen = '0;
    for (int i = 0; i < WIDTH; i++) cand[i] = '0;
    for (int p = 0; p < PHYS_REGS; p++) begin
      if (spec_free_reg[p]) begin
        for (int i = 0; i < WIDTH; i++)
          if (seen == need_before[i]) cand[i] = PW'(p);
        seen = seen + 1'b1;
      end
    end
  end

`ifdef RENAME_PARTIAL_ACCEPT_EN
  always_comb begin : p_fit
    logic ok;
    ok = 1'b1;
    fit_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ok = ok & in_valid[i] & (need_upto[i] <= free_count);
      fit_mask[i] = ok;
    end
  end
`else
  always_comb begin : p_fit
    fit_mask = (need_upto[WIDTH-1] <= free_count) ? in_valid : '0;
  end
`endif

  // Nothing is accepted during a flush cycle or while reset is held.
  assign accepted = (reset && !flush) ? fit_mask : '0;
  assign in_ready = reset && !flush && (fit_mask[0] || (in_valid == '0));

  // Sources and old destination see the youngest older in-group writer first.
  always_comb begin : p_lookup
    logic [PW-1:0] s1, s2, o;
    for (int i = 0; i < WIDTH; i++) begin
      s1 = (rs1_a[i] == '0) ? '0 : spec_rat_reg[rs1_a[i]];
      s2 = (rs2_a[i] == '0) ? '0 : spec_rat_reg[rs2_a[i]];
      o  = spec_rat_reg[rd_a[i]];
      for (int j = 0; j < i; j++) begin
        if (need[j] && rd_a[j] == rs1_a[i]) s1 = raw_rd[j];
        if (need[j] && rd_a[j] == rs2_a[i]) s2 = raw_rd[j];
        if (need[j] && rd_a[j] == rd_a[i])  o  = raw_rd[j];
      end
      rs1_out[i] = accepted[i] ? s1 : '0;
      rs2_out[i] = accepted[i] ? s2 : '0;
      rd_out[i]  = accepted[i] ? raw_rd[i] : '0;
      old_out[i] = (accepted[i] && need[i]) ? o : '0;
    end
  end

  always_comb begin : p_next_state
    spec_rat_next    = spec_rat_reg;
    commit_rat_next  = commit_rat_reg;
    spec_free_next   = spec_free_reg;
    commit_free_next = commit_free_reg;
    for (int i = 0; i < WIDTH; i++) begin
      if (accepted[i] && need[i]) begin
        spec_rat_next[rd_a[i]]    = raw_rd[i];
        spec_free_next[raw_rd[i]] = 1'b0;
      end
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (commit_valid[j] && c_arch[j] != '0) begin
        commit_rat_next[c_arch[j]] = c_new[j];
        commit_free_next[c_new[j]] = 1'b0;
        if (c_old[j] != '0) begin
          commit_free_next[c_old[j]] = 1'b1;
          spec_free_next[c_old[j]]   = 1'b1;
        end
      end
    end
    if (flush) begin
      spec_rat_next  = commit_rat_next;
      spec_free_next = commit_free_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_reg[i]   <= PW'(i);
        commit_rat_reg[i] <= PW'(i);
      end
      for (int p = 0; p < PHYS_REGS; p++) begin
        spec_free_reg[p]   <= (p >= ARCH_REGS);
        commit_free_reg[p] <= (p >= ARCH_REGS);
      end
    end else begin
      spec_rat_reg    <= spec_rat_next;
      commit_rat_reg  <= commit_rat_next;
      spec_free_reg   <= spec_free_next;
      commit_free_reg <= commit_free_next;
    end
  end

endmodule

// File: tb/tb_rename_table_multiway.sv
// Directed bench for rename_table_multiway (WIDTH=3, 32 arch / 64 phys); honours RENAME_PARTIAL_ACCEPT_EN.
module tb_rename_table_multiway;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_valid, rd_we;
  logic [14:0] rs1_arch, rs2_arch, rd_arch;
  logic        in_ready;
  logic [2:0]  accepted;
  logic [17:0] rs1_phys, rs2_phys, rd_phys, old_rd_phys;
  logic [2:0]  commit_valid;
  logic [14:0] commit_rd_arch;
  logic [17:0] commit_new_phys, commit_old_phys;
  logic        flush;
  logic [6:0]  free_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rename_table_multiway dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .rd_we(rd_we),
    .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch),
    .in_ready(in_ready), .accepted(accepted),
    .rs1_phys(rs1_phys), .rs2_phys(rs2_phys), .rd_phys(rd_phys), .old_rd_phys(old_rd_phys),
    .commit_valid(commit_valid), .commit_rd_arch(commit_rd_arch),
    .commit_new_phys(commit_new_phys), .commit_old_phys(commit_old_phys),
    .flush(flush), .free_count(free_count)
  );

  typedef struct {
    logic [2:0]  in_valid, rd_we;
    logic [14:0] rs1, rs2, rd;
    logic [2:0]  cv;
    logic [14:0] c_arch;
    logic [17:0] c_new, c_old;
    logic        flush;
    logic [2:0]  e_acc;
    logic        e_rdy;
    logic [17:0] e_rs1, e_rs2, e_rd, e_old;
    logic [6:0]  e_fc;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  function automatic logic [14:0] a3(input int s2, input int s1, input int s0);
    return {5'(s2), 5'(s1), 5'(s0)};
  endfunction

  function automatic logic [17:0] p3(input int s2, input int s1, input int s0);
    return {6'(s2), 6'(s1), 6'(s0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic idle_inputs();
    in_valid = '0; rd_we = '0; rs1_arch = '0; rs2_arch = '0; rd_arch = '0;
    commit_valid = '0; commit_rd_arch = '0; commit_new_phys = '0; commit_old_phys = '0;
    flush = 1'b0;
  endtask

  task automatic rename(input logic [2:0] v, input logic [2:0] we, input logic [14:0] r1,
                        input logic [14:0] r2, input logic [14:0] rd);
    in_valid = v; rd_we = we; rs1_arch = r1; rs2_arch = r2; rd_arch = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NV; k++) vecs[k] = '{default: '0};
    // 0: three fresh destinations from the initial free list.
    vecs[0].in_valid = 3'b111; vecs[0].rd_we = 3'b111; vecs[0].rd = a3(3, 2, 1);
    vecs[0].e_acc = 3'b111; vecs[0].e_rdy = 1'b1;
    vecs[0].e_rd = p3(34, 33, 32); vecs[0].e_old = p3(3, 2, 1); vecs[0].e_fc = 7'd32;
    // 1: in-group bypass of x5 to slot1 source and slot2 old mapping.
    vecs[1].in_valid = 3'b111; vecs[1].rd_we = 3'b101; vecs[1].rd = a3(5, 0, 5);
    vecs[1].rs1 = a3(2, 5, 1); vecs[1].rs2 = a3(3, 1, 0);
    vecs[1].e_acc = 3'b111; vecs[1].e_rdy = 1'b1;
    vecs[1].e_rs1 = p3(33, 35, 32); vecs[1].e_rs2 = p3(34, 32, 0);
    vecs[1].e_rd = p3(36, 0, 35); vecs[1].e_old = p3(35, 0, 5); vecs[1].e_fc = 7'd29;
    // 2: youngest writer won: x5 -> 36.
    vecs[2].in_valid = 3'b001; vecs[2].rs1 = a3(0, 0, 5); vecs[2].rs2 = a3(0, 0, 1);
    vecs[2].e_acc = 3'b001; vecs[2].e_rdy = 1'b1;
    vecs[2].e_rs1 = p3(0, 0, 36); vecs[2].e_rs2 = p3(0, 0, 32); vecs[2].e_fc = 7'd27;
    // 3: no valid slots: outputs read as zero, ready high.
    vecs[3].rs1 = a3(0, 0, 5); vecs[3].e_rdy = 1'b1; vecs[3].e_fc = 7'd27;
    // 4: commit x1 (new 32, old 1).
    vecs[4].cv = 3'b001; vecs[4].c_arch = a3(0, 0, 1);
    vecs[4].c_new = p3(0, 0, 32); vecs[4].c_old = p3(0, 0, 1);
    vecs[4].e_rdy = 1'b1; vecs[4].e_fc = 7'd27;
    // 5: freed phys 1 is now the lowest free register.
    vecs[5].in_valid = 3'b001; vecs[5].rd_we = 3'b001; vecs[5].rd = a3(0, 0, 7);
    vecs[5].rs1 = a3(0, 0, 1);
    vecs[5].e_acc = 3'b001; vecs[5].e_rdy = 1'b1; vecs[5].e_rs1 = p3(0, 0, 32);
    vecs[5].e_rd = p3(0, 0, 1); vecs[5].e_old = p3(0, 0, 7); vecs[5].e_fc = 7'd28;
    // 6: flush with a same-cycle commit of x2 (new 33, old 2): dead cycle.
    vecs[6].flush = 1'b1; vecs[6].cv = 3'b001; vecs[6].c_arch = a3(0, 0, 2);
    vecs[6].c_new = p3(0, 0, 33); vecs[6].c_old = p3(0, 0, 2);
    vecs[6].in_valid = 3'b001; vecs[6].rd_we = 3'b001; vecs[6].rd = a3(0, 0, 8);
    vecs[6].e_fc = 7'd27;
    // 7: restored committed map: x1->32, x2->33, x3/x5/x7 identity; free = {1,2,34..63}.
    vecs[7].in_valid = 3'b111; vecs[7].rd_we = 3'b100; vecs[7].rd = a3(9, 0, 0);
    vecs[7].rs1 = a3(7, 3, 1); vecs[7].rs2 = a3(0, 5, 2);
    vecs[7].e_acc = 3'b111; vecs[7].e_rdy = 1'b1;
    vecs[7].e_rs1 = p3(7, 3, 32); vecs[7].e_rs2 = p3(0, 5, 33);
    vecs[7].e_rd = p3(1, 0, 0); vecs[7].e_old = p3(9, 0, 0); vecs[7].e_fc = 7'd32;
    // 8: idle, free count after the allocation.
    vecs[8].e_rdy = 1'b1; vecs[8].e_fc = 7'd31;

    idle_inputs();
    reset = 1'b0;
    #12;
    chk("reset.free_count", 32'(free_count), 32'd32);
    chk("reset.accepted", 32'(accepted), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) begin
      rename(vecs[k].in_valid, vecs[k].rd_we, vecs[k].rs1, vecs[k].rs2, vecs[k].rd);
      commit_valid = vecs[k].cv; commit_rd_arch = vecs[k].c_arch;
      commit_new_phys = vecs[k].c_new; commit_old_phys = vecs[k].c_old;
      flush = vecs[k].flush;
      #2;
      chk($sformatf("v%0d.accepted", k), 32'(accepted), 32'(vecs[k].e_acc));
      chk($sformatf("v%0d.in_ready", k), 32'(in_ready), 32'(vecs[k].e_rdy));
      chk($sformatf("v%0d.rs1_phys", k), 32'(rs1_phys), 32'(vecs[k].e_rs1));
      chk($sformatf("v%0d.rs2_phys", k), 32'(rs2_phys), 32'(vecs[k].e_rs2));
      chk($sformatf("v%0d.rd_phys", k), 32'(rd_phys), 32'(vecs[k].e_rd));
      chk($sformatf("v%0d.old_rd_phys", k), 32'(old_rd_phys), 32'(vecs[k].e_old));
      chk($sformatf("v%0d.free_count", k), 32'(free_count), 32'(vecs[k].e_fc));
      @(posedge clk); #1;
    end
    idle_inputs();

    // Drain 31 free registers down to 1 with ten full groups.
    for (int g = 0; g < 10; g++) begin
      rename(3'b111, 3'b111, '0, '0, a3(12, 11, 10));
      #2;
      chk($sformatf("drain%0d.accepted", g), 32'(accepted), 32'h7);
      @(posedge clk); #1;
    end
    idle_inputs();
    #2;
    chk("drain.free_count", 32'(free_count), 32'd1);

    // Two allocations against one free register.
    rename(3'b011, 3'b011, '0, '0, a3(0, 14, 13));
    #2;
`ifdef RENAME_PARTIAL_ACCEPT_EN
    chk("short.accepted", 32'(accepted), 32'h1);
    chk("short.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
`else
    chk("short.accepted", 32'(accepted), 32'h0);
    chk("short.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rename(3'b001, 3'b001, '0, '0, a3(0, 0, 15));
    #2;
    chk("last.accepted", 32'(accepted), 32'h1);
    @(posedge clk); #1;
`endif
    idle_inputs();
    #2;
    chk("empty.free_count", 32'(free_count), 32'd0);

    // Rename stalls on an empty list while a commit frees phys 4 the same cycle.
    rename(3'b001, 3'b001, '0, '0, a3(0, 0, 13));
    commit_valid = 3'b001; commit_rd_arch = a3(0, 0, 4);
    commit_new_phys = p3(0, 0, 40); commit_old_phys = p3(0, 0, 4);
    #1;
    chk("stall.accepted", 32'(accepted), 32'h0);
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    commit_valid = '0;
    #2;
    chk("retry.free_count", 32'(free_count), 32'd1);
    chk("retry.accepted", 32'(accepted), 32'h1);
    chk("retry.rd_phys", 32'(rd_phys), 32'(p3(0, 0, 4)));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a group.
    rename(3'b111, 3'b111, '0, '0, a3(3, 2, 1));
    reset = 1'b0;
    #1;
    chk("areset.free_count", 32'(free_count), 32'd32);
    chk("areset.accepted", 32'(accepted), 32'h0);
    chk("areset.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    rename(3'b111, 3'b001, a3(3, 0, 1), a3(0, 9, 0), a3(0, 0, 3));
    #2;
    chk("post.accepted", 32'(accepted), 32'h7);
    chk("post.rs1_phys", 32'(rs1_phys), 32'(p3(32, 0, 1)));
    chk("post.rs2_phys", 32'(rs2_phys), 32'(p3(0, 9, 0)));
    chk("post.rd_phys", 32'(rd_phys), 32'(p3(0, 0, 32)));
    chk("post.old_rd_phys", 32'(old_rd_phys), 32'(p3(0, 0, 3)));
    @(posedge clk); #1;
    idle_inputs();
    #2;
    chk("post.free_count", 32'(free_count), 32'd31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
